// File: rtl/uart_core_if.sv
// Byte-side handshake between uart_core and its user: transmit request/status and received-byte delivery.
interface uart_core_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_clkpulse;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;

  modport master (
    output tx_data, tx_start,
    input  tx_busy, tx_clkpulse, rx_data, rx_valid, rx_busy
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_busy, tx_clkpulse, rx_data, rx_valid, rx_busy
  );
endinterface

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: independent TX and RX state machines timed by one integer baud divider.
module uart_core #(
  parameter int CLK_FREQ_MHZ = 12,
  parameter int BAUD         = 115200
) (
  input  logic        clk,
  input  logic        rst,
  output logic        tx,
  input  logic        rx,
  uart_core_if.slave  bus
);
  localparam int DIVIDER = CLK_FREQ_MHZ * 1_000_000 / BAUD;
  localparam int DW      = $clog2(DIVIDER) + 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIVIDER - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(DIVIDER / 2 - 1);

  // ---------------- transmitter ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     tx_state_reg, tx_state_next;
  logic [DW-1:0] tx_div_reg, tx_div_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [7:0]    tx_shift_reg, tx_shift_next;
  logic          tx_reg, tx_next;
  logic          tx_bit_end;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_reg <= TX_IDLE;
      tx_div_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_reg       <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_div_reg   <= tx_div_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_reg       <= tx_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_div_next   = tx_div_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_next       = 1'b1;
    tx_bit_end    = (tx_div_reg == DIV_LAST);

    if (tx_state_reg == TX_IDLE) begin
      tx_div_next = '0;
      tx_bit_next = '0;
      if (bus.tx_start) begin
        tx_shift_next = bus.tx_data;
        tx_state_next = TX_START;
      end
    end else begin
      tx_div_next = tx_bit_end ? '0 : tx_div_reg + DW'(1);
      unique case (tx_state_reg)
        TX_START: if (tx_bit_end) tx_state_next = TX_DATA;
        TX_DATA: if (tx_bit_end) begin
          if (tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
          else                    tx_bit_next   = tx_bit_reg + 3'd1;
        end
        TX_STOP: if (tx_bit_end) tx_state_next = TX_IDLE;
        default: tx_state_next = TX_IDLE;
      endcase
    end

    // Line level is decoded from the next state so the pin itself is a flop and never glitches.
    unique case (tx_state_next)
      TX_IDLE:  tx_next = 1'b1;
      TX_START: tx_next = 1'b0;
      TX_DATA:  tx_next = tx_shift_next[tx_bit_next];
      TX_STOP:  tx_next = 1'b1;
      default:  tx_next = 1'b1;
    endcase
  end

  assign tx              = tx_reg;
  assign bus.tx_busy     = (tx_state_reg != TX_IDLE);
  assign bus.tx_clkpulse = (tx_state_reg != TX_IDLE) && tx_bit_end;

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state_reg, rx_state_next;
  logic [DW-1:0] rx_div_reg, rx_div_next;
  logic [2:0]    rx_bit_reg, rx_bit_next;
  logic [7:0]    rx_shift_reg, rx_shift_next;
  logic [7:0]    rx_data_reg, rx_data_next;
  logic          rx_valid_reg, rx_valid_next;
  logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic          rx_fall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_div_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_meta_reg  <= rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_state_reg <= rx_state_next;
      rx_div_reg   <= rx_div_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
    end
  end

  assign rx_fall = rx_prev_reg & ~rx_sync_reg;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_div_next   = rx_div_reg + DW'(1);
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;

    unique case (rx_state_reg)
      RX_IDLE: begin
        rx_div_next = '0;
        rx_bit_next = '0;
        if (rx_fall) rx_state_next = RX_START;
      end
      // Half a bit after the edge: a line that is high again was only a glitch.
      RX_START: if (rx_div_reg == HALF_LAST) begin
        rx_div_next   = '0;
        rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_div_reg == DIV_LAST) begin
        rx_div_next   = '0;
        rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
        if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
        else                    rx_bit_next   = rx_bit_reg + 3'd1;
      end
      RX_STOP: if (rx_div_reg == DIV_LAST) begin
        rx_div_next   = '0;
        rx_state_next = RX_IDLE;
        if (rx_sync_reg) begin
          rx_data_next  = rx_shift_reg;
          rx_valid_next = 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign bus.rx_busy  = (rx_state_reg != RX_IDLE);
endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core at 12 MHz / 1.2 Mbaud: frame-level TX model, RX byte scoreboard, directed vectors.
module tb_uart_core;
  localparam int CLK_FREQ_MHZ = 12;
  localparam int BAUD         = 1200000;
  localparam int D            = CLK_FREQ_MHZ * 1_000_000 / BAUD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  logic rx_drv  = 1'b1;
  logic loop_en = 1'b0;
  wire  rx;
  assign rx = loop_en ? tx : rx_drv;

  uart_core_if bus ();

  uart_core #(.CLK_FREQ_MHZ(CLK_FREQ_MHZ), .BAUD(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .tx  (tx),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Frame model: a frame is a position k in 0..10*D-1; bit index k/D selects start, data, stop.
  logic       started = 1'b0;
  logic       rx_clear = 1'b0;
  logic       m_busy = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_rx_last = 8'h00;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    started  <= 1'b1;
    rx_clear <= !rst;
    if (!rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else if (m_busy) begin
      if (m_k == 10*D - 1) begin
        m_busy <= 1'b0;
        m_k    <= 0;
      end else begin
        m_k <= m_k + 1;
      end
    end else if (bus.tx_start) begin
      m_busy <= 1'b1;
      m_k    <= 0;
      m_byte <= bus.tx_data;
    end
  end

  logic exp_tx, exp_pulse;
  int   idx;

  always @(negedge clk) begin
    if (started) begin
      exp_tx    = 1'b1;
      exp_pulse = 1'b0;
      if (m_busy) begin
        idx       = m_k / D;
        exp_pulse = ((m_k % D) == D - 1);
        if (idx == 0)      exp_tx = 1'b0;
        else if (idx <= 8) exp_tx = m_byte[3'(idx - 1)];
      end
      check("tx", tx, exp_tx);
      check("tx_busy", bus.tx_busy, m_busy);
      check("tx_clkpulse", bus.tx_clkpulse, exp_pulse);
      if (rx_clear) m_rx_last = 8'h00;
      if (bus.rx_valid === 1'b1) begin
        if (exp_q.size() == 0) check("rx_valid_unexpected", bus.rx_valid, 1'b0);
        else                   m_rx_last = exp_q.pop_front();
      end
      check("rx_data", bus.rx_data, m_rx_last);
    end
  end

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (D) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rx_drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20*D) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check(nm, exp_q.size(), 0);
  endtask

  logic [9:0] a61_bits;
  logic       pulse_tx[10];
  int         np, busy_cnt, gap, ngaps;
  logic       prev_busy, in_gap;

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    a61_bits     = 10'b10_1100_0010;

    // Reset held for two clocks
    repeat (2) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_tx_busy", bus.tx_busy, 1'b0);
    check("reset_tx_clkpulse", bus.tx_clkpulse, 1'b0);
    check("reset_rx_valid", bus.rx_valid, 1'b0);
    check("reset_rx_busy", bus.rx_busy, 1'b0);
    check("reset_rx_data", bus.rx_data, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame of 8'h61 with a one-clock start pulse
    bus.tx_data  = 8'h61;
    bus.tx_start = 1'b1;
    np = 0;
    busy_cnt = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (i == 0) bus.tx_start = 1'b0;
      if (bus.tx_busy) busy_cnt++;
      if (bus.tx_clkpulse) begin
        if (np < 10) pulse_tx[np] = tx;
        np++;
      end
    end
    check("a61_pulse_count", np, 10);
    for (int i = 0; i < 10; i++) check($sformatf("a61_bit%0d", i), pulse_tx[i], a61_bits[i]);
    check("a61_busy_clocks", busy_cnt, 10*D);

    // Continuous start: one idle clock between frames; data change mid-frame waits for next frame
    bus.tx_data  = 8'h3C;
    bus.tx_start = 1'b1;
    prev_busy = 1'b0;
    in_gap = 1'b0;
    gap = 0;
    ngaps = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (i == 150) bus.tx_data = 8'hC3;
      if (bus.tx_busy) begin
        if (in_gap) begin
          check("inter_frame_gap", gap, 1);
          ngaps++;
          in_gap = 1'b0;
        end
      end else if (prev_busy) begin
        in_gap = 1'b1;
        gap = 1;
      end else if (in_gap) begin
        gap++;
      end
      prev_busy = bus.tx_busy;
    end
    check("gap_count", ngaps, 2);
    bus.tx_start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tx_busy) busy_cnt++;
    end
    check("tail_busy_clocks", busy_cnt, 52);
    check("tail_idle", bus.tx_busy, 1'b0);

    // Reset in the middle of a frame
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    repeat (35) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_tx", tx, 1'b1);
    check("midreset_busy", bus.tx_busy, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Loopback of 8'hA5
    loop_en = 1'b1;
    exp_q.push_back(8'hA5);
    bus.tx_data  = 8'hA5;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    repeat (39) @(negedge clk);
    check("loop_rx_busy_mid", bus.rx_busy, 1'b1);
    wait_rx_drain("loop_rx_valid_seen");
    repeat (5) @(negedge clk);
    check("loop_rx_busy_after", bus.rx_busy, 1'b0);
    check("loop_rx_data", bus.rx_data, 8'hA5);
    repeat (10) @(negedge clk);
    loop_en = 1'b0;
    repeat (3) @(negedge clk);

    // Directly driven good frame
    exp_q.push_back(8'h5A);
    drive_rx_frame(8'h5A, 1'b1);
    wait_rx_drain("drv_rx_valid_seen");
    check("drv_rx_data", bus.rx_data, 8'h5A);
    repeat (5) @(negedge clk);

    // Framing error: stop bit low
    drive_rx_frame(8'h3C, 1'b0);
    repeat (30) @(negedge clk);
    check("ferr_rx_busy", bus.rx_busy, 1'b0);
    check("ferr_rx_data", bus.rx_data, 8'h5A);

    // Glitch shorter than half a bit
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_rx_busy_set", bus.rx_busy, 1'b1);
    repeat (15) @(negedge clk);
    check("glitch_rx_busy_clear", bus.rx_busy, 1'b0);
    repeat (2*D) @(negedge clk);
    check("rx_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/uart_core.md
# uart_core

Full-duplex 8N1 UART with independent transmitter and receiver, both timed from a single system clock by an integer baud divider. It sits between a byte-wide internal interface and the serial pins. The transmitter exports a per-bit strobe so benches and neighbouring logic can align to bit boundaries.

## Interface
Parameters:
- CLK_FREQ_MHZ, 12: system clock frequency in MHz.
- BAUD, 115200: serial bit rate.
- DIVIDER (derived): CLK_FREQ_MHZ*1_000_000/BAUD, truncated; clocks per bit; must be ≥ 2. With BAUD=1200000 at 12 MHz, DIVIDER = 10.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- tx  out  1  serial transmit line; idles high.
- tx_data  in  8  byte to transmit; captured when a frame starts.
- tx_start  in  1  level request: send tx_data whenever the transmitter is idle.
- tx_busy  out  1  high for the whole frame being sent.
- tx_clkpulse  out  1  one-clock strobe in the last clock of each transmitted bit period.
- rx  in  1  serial receive line (asynchronous).
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-clock pulse when rx_data is updated.
- rx_busy  out  1  high while a frame is being received.

## Operation
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). No parity.
- The TX state machine has four states: IDLE, START, DATA, STOP.
- TX in IDLE:
  - tx=1, tx_busy=0, bit counter cleared.
  - If tx_start=1, latch tx_data into a shift register, go to START, set tx_busy=1.
- TX in START, DATA, STOP:
  - Each bit lasts exactly DIVIDER clocks.
  - tx_clkpulse=1 only when the divider count equals DIVIDER-1. On that clock, tx still carries the current bit.
  - The state and bit advance on the next edge.
  - DATA sends shift-register bits 0..7 in order.
  - After the last STOP clock, return to IDLE.
- After a frame, TX always spends at least one clock in IDLE with tx_busy=0, even when tx_start stays high. Back-to-back frames are therefore separated by one idle clock.
- Changing tx_data or tx_start while tx_busy=1 has no effect on the current frame.
- RX input path: a 2-flop synchronizer feeds falling-edge detection.
- RX frame reception:
  - A falling edge in idle sets rx_busy=1 and waits DIVIDER/2 clocks.
  - If rx is still 0, it is a valid start bit; otherwise return to idle (glitch).
  - Sample 8 data bits at mid-bit, every DIVIDER clocks, LSB first, then sample the stop bit.
- RX completion:
  - Stop=1: load rx_data and pulse rx_valid for one clock.
  - Stop=0 (framing error): discard the byte; rx_data is unchanged and there is no pulse.
  - In both cases, deassert rx_busy and return to idle.
  - The next falling edge is accepted only after the stop-bit sample.

## Timing
- Reset values, applied on a clock edge with rst=0: tx=1, tx_busy=0, tx_clkpulse=0, rx_data=0, rx_valid=0, rx_busy=0. All counters are cleared and both state machines go to idle.
- Reset mid-frame aborts the frame immediately: tx returns high on the next edge.
- TX latency: tx_start sampled high in IDLE → tx=0 and tx_busy=1 from the next clock.
- tx_busy stays high for exactly 10*DIVIDER clocks.
- tx_clkpulse fires 10 times per frame, at clocks DIVIDER-1, 2*DIVIDER-1, … relative to the first busy clock. It is never asserted in IDLE.
- RX: rx_valid asserts within 2 clocks after the stop-bit mid-sample, i.e. about 9.5*DIVIDER + 3 clocks after the rx falling edge.
- Divider arithmetic is unsigned, with width $clog2(DIVIDER)+1. The divider count wraps to 0 after DIVIDER-1.

## Test plan
- Reset: hold rst=0 for 2 clocks → tx=1, tx_busy=0, tx_clkpulse=0, rx_valid=0, rx_busy=0.
- Single TX frame (BAUD=1200000, 12 MHz): tx_data=8'h61 ("a") with tx_start pulsed → at the 10 successive tx_clkpulse strobes, tx = 0,1,0,0,0,0,1,1,0,1. tx_busy is high for 100 clocks, then low.
- Continuous tx_start=1: frames repeat. tx_busy drops for exactly 1 clock between frames, and every frame carries the byte latched at its start. Deasserting tx_start mid-frame completes the frame, then TX stays idle.
- Loopback (rx tied to tx): send 8'hA5 → one rx_valid pulse with rx_data=8'hA5. rx_busy is high during the frame.
- RX framing error: drive start, data 8'h3C, stop=0 → no rx_valid, rx_data unchanged, rx_busy returns low.
- RX glitch: rx low for fewer than DIVIDER/2 clocks → no reception, rx_busy returns to 0 and rx_valid never pulses.
